// File: rtl/fir_err_monitor.sv
// Windowed error-metric accumulator comparing approximate and exact FIR outputs.
// Two-stage pipeline: |approx-exact| register, then sum/max/nonzero-count update.
module fir_err_monitor #(
   parameter int unsigned DW       = 16,
   parameter int unsigned WIN_LOG2 = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [DW-1:0]          approx_in,
   input  logic [DW-1:0]          exact_in,
   input  logic                   res_ack,
   output logic                   busy,
   output logic                   done,
   output logic [DW+WIN_LOG2-1:0] err_sum,
   output logic [DW-1:0]          err_max,
   output logic [WIN_LOG2:0]      err_cnt,
   output logic [DW-1:0]          err_mean
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [WIN_LOG2:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

   state_t              state, state_nxt;
   logic [WIN_LOG2:0]   smp_cnt;
   logic                win_full;
   logic                accept;
   logic                clear;

   logic [DW:0]         diff;
   logic [DW:0]         neg_diff;
   logic [DW-1:0]       abs_diff;
   logic [DW-1:0]       s1_abs;
   logic                s1_nz;
   logic                s1_valid;

   assign win_full = (smp_cnt == WIN_LEN);

   // The window closes one cycle after the last accept (counter full), so the
   // final sample has left stage 1 before DRAIN lets it settle in stage 2.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      clear     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (win_full) state_nxt = DRAIN;
            else          accept    = in_valid;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            done = 1'b1;
            if (res_ack) begin
               if (start) begin
                  clear     = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   assign diff     = {1'b0, approx_in} - {1'b0, exact_in};
   assign neg_diff = '0 - diff;
   assign abs_diff = diff[DW] ? neg_diff[DW-1:0] : diff[DW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_cnt  <= '0;
         s1_valid <= 1'b0;
         s1_abs   <= '0;
         s1_nz    <= 1'b0;
      end else if (clear) begin
         smp_cnt  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            smp_cnt <= smp_cnt + 1'b1;
            s1_abs  <= abs_diff;
            s1_nz   <= (approx_in != exact_in);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sum <= '0;
         err_max <= '0;
         err_cnt <= '0;
      end else if (clear) begin
         err_sum <= '0;
         err_max <= '0;
         err_cnt <= '0;
      end else if (s1_valid) begin
         err_sum <= err_sum + {{WIN_LOG2{1'b0}}, s1_abs};
         if (s1_abs > err_max) err_max <= s1_abs;
         err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, s1_nz};
      end
   end

   assign err_mean = err_sum[DW+WIN_LOG2-1:WIN_LOG2];

endmodule

// File: tb/tb_fir_err_monitor.sv
// Scoreboard bench for fir_err_monitor (DW=16, window of 4 samples).
module tb_fir_err_monitor;

   localparam int DW = 16;
   localparam int WL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] approx_in = '0;
   logic [DW-1:0] exact_in = '0;
   logic          res_ack = 1'b0;
   logic          busy, done;
   logic [DW+WL-1:0] err_sum;
   logic [DW-1:0]    err_max;
   logic [WL:0]      err_cnt;
   logic [DW-1:0]    err_mean;

   fir_err_monitor #(.DW(DW), .WIN_LOG2(WL)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .approx_in(approx_in), .exact_in(exact_in), .res_ack(res_ack),
      .busy(busy), .done(done), .err_sum(err_sum), .err_max(err_max),
      .err_cnt(err_cnt), .err_mean(err_mean)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint sum;
      longint mx;
      longint cnt;
      longint mean;
      int     cyc;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] wa[4];
   logic [DW-1:0] we[4];

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Window metrics straight from the definitions: sum/max/count of |a-e|, mean = sum/window.
   function automatic exp_t model();
      exp_t r;
      r.sum = 0; r.mx = 0; r.cnt = 0; r.cyc = 0;
      for (int i = 0; i < 4; i++) begin
         longint d;
         d = longint'(wa[i]) - longint'(we[i]);
         if (d < 0) d = -d;
         r.sum += d;
         if (d > r.mx) r.mx = d;
         if (d != 0) r.cnt++;
      end
      r.mean = r.sum / 4;
      return r;
   endfunction

   logic done_d = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         done_d <= 1'b0;
      end else begin
         if (done && !done_d) begin
            if (sbq.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               check("err_sum", err_sum, e.sum);
               check("err_max", err_max, e.mx);
               check("err_cnt", err_cnt, e.cnt);
               check("err_mean", err_mean, e.mean);
               check("done_latency_cycle", cyc, e.cyc);
               check("busy_in_hold", busy, 0);
            end
         end
         done_d <= done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic open_window();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic ack_only();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
      check("ack_done_low", done, 0);
      check("ack_busy_low", busy, 0);
   endtask

   task automatic feed(input int gmin, input int gmax, input bit junk);
      int   k;
      exp_t e;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         int g;
         g = int'($urandom_range(gmax, gmin));
         in_valid = 1'b0;
         repeat (g) begin
            approx_in = DW'($urandom);
            exact_in  = DW'($urandom);
            tick();
         end
         in_valid  = 1'b1;
         approx_in = wa[i];
         exact_in  = we[i];
         k = cyc;
         tick();
      end
      in_valid = 1'b0;
      e = model();
      e.cyc = k + 3;
      sbq.push_back(e);
      for (int n = 0; n < 20 && !done; n++) begin
         if (junk) begin
            in_valid  = 1'($urandom_range(1, 0));
            approx_in = DW'($urandom);
            exact_in  = DW'($urandom);
         end
         tick();
      end
      if (!done) check("done_timeout", 0, 1);
      if (junk) begin
         repeat (3) begin
            in_valid  = 1'b1;
            approx_in = DW'($urandom);
            exact_in  = DW'($urandom);
            tick();
         end
         in_valid = 1'b0;
         check("hold_sum_stable", err_sum, e.sum);
         check("hold_cnt_stable", err_cnt, e.cnt);
      end
      in_valid = 1'b0;
   endtask

   task automatic set_t2();
      wa[0] = 10; wa[1] = 20; wa[2] = 30; wa[3] = 40;
      we[0] = 12; we[1] = 20; we[2] = 25; we[3] = 40;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", err_sum, 0);
      check("rst_cnt", err_cnt, 0);
      rst = 1'b0;
      tick();

      // identical streams
      wa[0] = 5; wa[1] = 9; wa[2] = 100; wa[3] = 7;
      we = wa;
      open_window();
      check("run_busy", busy, 1);
      feed(0, 0, 1'b0);
      ack_only();

      // mixed errors, then the same data gapped every third cycle with HOLD junk
      set_t2();
      open_window();
      feed(0, 0, 1'b1);
      check("t2_sum_literal", err_sum, 7);
      check("t2_mean_literal", err_mean, 1);
      ack_only();
      check("idle_retains_sum", err_sum, 7);
      open_window();
      feed(2, 2, 1'b1);
      ack_only();

      // extremes
      for (int i = 0; i < 4; i++) begin
         wa[i] = 16'hFFFF;
         we[i] = 16'h0000;
      end
      open_window();
      feed(0, 0, 1'b0);
      check("t4_sum_literal", err_sum, 'h3FFFC);

      // HOLD handshake: start alone, then start+ack, then ack alone
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_start_ignored_done", done, 1);
      check("hold_start_ignored_busy", busy, 0);
      check("hold_start_ignored_sum", err_sum, 'h3FFFC);
      start = 1'b1;
      res_ack = 1'b1;
      tick();
      start = 1'b0;
      res_ack = 1'b0;
      check("restart_done", done, 0);
      check("restart_busy", busy, 1);
      check("restart_sum", err_sum, 0);
      check("restart_max", err_max, 0);
      check("restart_cnt", err_cnt, 0);
      set_t2();
      feed(0, 1, 1'b0);
      ack_only();
      check("ack_retains_sum", err_sum, 7);
      check("ack_retains_cnt", err_cnt, 2);

      // asynchronous reset after two accepted samples
      for (int i = 0; i < 4; i++) begin
         wa[i] = DW'(1000 + i);
         we[i] = DW'(3);
      end
      open_window();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         approx_in = wa[i];
         exact_in = we[i];
         tick();
      end
      in_valid = 1'b0;
      tick();
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      check("async_rst_sum", err_sum, 0);
      check("async_rst_max", err_max, 0);
      check("async_rst_cnt", err_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      set_t2();
      open_window();
      feed(0, 0, 1'b0);
      ack_only();

      // randomized windows
      for (int w = 0; w < 10; w++) begin
         for (int i = 0; i < 4; i++) begin
            int mode;
            wa[i] = DW'($urandom);
            mode = int'($urandom_range(3, 0));
            case (mode)
               0: we[i] = wa[i];
               1: we[i] = DW'($urandom);
               2: we[i] = wa[i] + DW'($urandom_range(8, 1));
               default: we[i] = wa[i] ^ (DW'(1) << $urandom_range(15, 0));
            endcase
         end
         open_window();
         feed(0, 3, 1'(w % 2));
         ack_only();
      end

      tick();
      tick();
      check("scoreboard_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
